oh_csa_acc: RTL and testbench

- Pipelined multi-operand carry-save accumulator: each accepted beat compresses N operands plus the running redundant (sum, carry) state through a 3:2 CSA tree.
- The carry-propagate add happens once per packet, not once per beat.
- Used in DSP/MAC datapaths and checksum engines where many operands reduce to a single result.
- Valid/ready on input and output; packets are delimited by in_last.

---
 rtl/oh_csa_acc.sv | 146 ++++++++++++++
 tb/tb_oh_csa_acc.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/oh_csa_acc.sv
// Multi-operand carry-save accumulator.
// Each accepted beat folds N operands into a redundant (sum, carry) pair
// through a chain of 3:2 compressors. The carry-propagate add happens only
// once per packet, in the RESOLVE state, so the per-beat path is a few XOR/majority levels
// and never a full-width adder.
module oh_csa_acc #(
  parameter int DW = 16,
  parameter int N  = 3,
  parameter int AW = 32,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AW-1:0]   out_sum,
  output logic [CW-1:0]   out_count
);

  typedef enum logic [1:0] {
    ACC     = 2'd0,
    RESOLVE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [AW-1:0] s_reg, c_reg;
  logic [CW-1:0] count_reg;
  logic          out_valid_reg;
  logic [AW-1:0] out_sum_reg;
  logic [CW-1:0] out_count_reg;

  logic accept;   // beat taken this cycle
  logic resolve;  // redundant pair resolved this cycle
  logic done;     // output handshake this cycle

  // Compressor chain: stage gi folds operand gi into the running (s, c)
  // pair. With N=1 this is a single 3:2 stage.
  logic [AW-1:0] s_chain [0:N];
  logic [AW-1:0] c_chain [0:N];

  assign s_chain[0] = s_reg;
  assign c_chain[0] = c_reg;

  for (genvar gi = 0; gi < N; gi++) begin : g_csa
    logic [AW-1:0] op;
    logic [AW-1:0] maj;
    assign op  = AW'(in_data[gi*DW +: DW]);
    assign maj = (s_chain[gi] & c_chain[gi]) |
                 (s_chain[gi] & op) |
                 (c_chain[gi] & op);
    assign s_chain[gi+1] = s_chain[gi] ^ c_chain[gi] ^ op;
    // Carries move up one bit; the bit leaving the top is dropped (mod 2^AW).
    assign c_chain[gi+1] = maj << 1;
  end

  // State register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg <= ACC;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and control decode; clear overrides every transition.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    accept     = 1'b0;
    resolve    = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          if (in_last) state_next = RESOLVE;
        end
      end
      RESOLVE: begin
        resolve    = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          done       = 1'b1;
          state_next = ACC;
        end
      end
      default: state_next = ACC;
    endcase
    if (clear) begin
      state_next = ACC;
      accept     = 1'b0;
      resolve    = 1'b0;
      done       = 1'b0;
    end
  end

  // Accumulator, beat counter and result registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s_reg         <= '0;
      c_reg         <= '0;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_sum_reg   <= '0;
      out_count_reg <= '0;
    end else if (clear) begin
      // The last result stays visible on out_sum/out_count.
      s_reg         <= '0;
      c_reg         <= '0;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      if (accept) begin
        s_reg     <= s_chain[N];
        c_reg     <= c_chain[N];
        count_reg <= (count_reg == {CW{1'b1}}) ? count_reg : count_reg + CW'(1);
      end
      if (resolve) begin
        out_sum_reg   <= s_reg + c_reg;
        out_count_reg <= count_reg;
        out_valid_reg <= 1'b1;
      end
      if (done) begin
        s_reg         <= '0;
        c_reg         <= '0;
        count_reg     <= '0;
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_sum   = out_sum_reg;
  assign out_count = out_count_reg;

endmodule

// File: tb/tb_oh_csa_acc.sv
// Directed bench for oh_csa_acc: a table of packets plus hand-written
// sequences for latency, output stall, clear and asynchronous reset.
module tb_oh_csa_acc;

  localparam int DW = 8;
  localparam int N  = 3;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            nreset = 1'b0;
  logic            clear = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N*DW-1:0] in_data = '0;
  logic            in_last = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [15:0]     out_sum;
  logic [CW-1:0]   out_count;

  // Narrow-accumulator instance for the wrap-around case.
  logic            in_valid10 = 1'b0;
  logic            in_ready10;
  logic            out_valid10;
  logic            out_ready10 = 1'b0;
  logic [9:0]      out_sum10;
  logic [CW-1:0]   out_count10;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  oh_csa_acc #(.DW(DW), .N(N), .AW(16), .CW(CW)) u_dut (
    .clk(clk), .nreset(nreset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count)
  );

  oh_csa_acc #(.DW(DW), .N(N), .AW(10), .CW(CW)) u_dut10 (
    .clk(clk), .nreset(nreset), .clear(clear),
    .in_valid(in_valid10), .in_ready(in_ready10), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid10), .out_ready(out_ready10), .out_sum(out_sum10), .out_count(out_count10)
  );

  typedef struct {
    logic [7:0] a, b, c;
    logic       last;
    int         exp_sum;
    int         exp_cnt;
  } vec_t;

  vec_t vecs [0:8];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Present one beat from a negedge and hold it until it is accepted.
  task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic last);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = {c, b, a};
    in_last  = last;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("beat_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait for a result, compare it, then complete the output handshake.
  task automatic get_result(input string name, input int exp_sum, input int exp_cnt);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, int'(out_valid), 1);
    chk({name, "_sum"}, int'(out_sum), exp_sum);
    chk({name, "_count"}, int'(out_count), exp_cnt);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{a: 8'd1,   b: 8'd2,   c: 8'd3,   last: 1'b1, exp_sum: 6,    exp_cnt: 1};
    vecs[1] = '{a: 8'd255, b: 8'd255, c: 8'd255, last: 1'b0, exp_sum: 0,    exp_cnt: 0};
    vecs[2] = '{a: 8'd255, b: 8'd255, c: 8'd255, last: 1'b0, exp_sum: 0,    exp_cnt: 0};
    vecs[3] = '{a: 8'd255, b: 8'd255, c: 8'd255, last: 1'b0, exp_sum: 0,    exp_cnt: 0};
    vecs[4] = '{a: 8'd255, b: 8'd255, c: 8'd255, last: 1'b1, exp_sum: 3060, exp_cnt: 4};
    vecs[5] = '{a: 8'd7,   b: 8'd0,   c: 8'd0,   last: 1'b1, exp_sum: 7,    exp_cnt: 1};
    vecs[6] = '{a: 8'd100, b: 8'd200, c: 8'd50,  last: 1'b0, exp_sum: 0,    exp_cnt: 0};
    vecs[7] = '{a: 8'd0,   b: 8'd0,   c: 8'd0,   last: 1'b1, exp_sum: 350,  exp_cnt: 2};
    vecs[8] = '{a: 8'd0,   b: 8'd0,   c: 8'd0,   last: 1'b1, exp_sum: 0,    exp_cnt: 1};

    // Reset values.
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_out_count", int'(out_count), 0);
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);

    // Latency: result appears one edge after the RESOLVE state.
    beat(8'd1, 8'd2, 8'd3, 1'b1);
    chk("lat_valid_early", int'(out_valid), 0);
    chk("lat_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    chk("lat_valid", int'(out_valid), 1);
    get_result("lat", 6, 1);
    chk("lat_post_in_ready", int'(in_ready), 1);
    chk("lat_post_valid", int'(out_valid), 0);

    // Four back-to-back beats, then a five-cycle output stall.
    for (int i = 0; i < 4; i++) beat(8'd255, 8'd255, 8'd255, i == 3);
    chk("stall_in_ready_after_last", int'(in_ready), 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_sum", int'(out_sum), 3060);
      chk("stall_count", int'(out_count), 4);
      chk("stall_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
    end
    get_result("stall", 3060, 4);
    beat(8'd7, 8'd0, 8'd0, 1'b1);
    get_result("after_stall", 7, 1);

    // Table of packets.
    for (int i = 0; i < 9; i++) begin
      beat(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].last);
      if (vecs[i].last) get_result($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].exp_cnt);
    end

    // Clear while holding a result: valid drops, result value stays.
    beat(8'd5, 8'd5, 8'd5, 1'b1);
    @(posedge clk);
    #1;
    chk("hclr_valid_before", int'(out_valid), 1);
    @(negedge clk);
    clear = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    out_ready = 1'b0;
    chk("hclr_valid", int'(out_valid), 0);
    chk("hclr_in_ready", int'(in_ready), 1);
    chk("hclr_sum_kept", int'(out_sum), 15);

    // Clear mid-packet discards partial state.
    beat(8'd10, 8'd10, 8'd10, 1'b0);
    beat(8'd10, 8'd10, 8'd10, 1'b0);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    beat(8'd1, 8'd1, 8'd1, 1'b1);
    get_result("clr", 3, 1);

    // Clear on the same edge as an offered beat: the beat is dropped.
    @(negedge clk);
    clear = 1'b1;
    in_valid = 1'b1;
    in_data = {8'd9, 8'd9, 8'd9};
    in_last = 1'b0;
    @(posedge clk);
    #1;
    clear = 1'b0;
    in_valid = 1'b0;
    beat(8'd2, 8'd0, 8'd0, 1'b1);
    get_result("clr_beat", 2, 1);

    // Asynchronous reset while holding a result.
    beat(8'd10, 8'd10, 8'd10, 1'b0);
    beat(8'd1, 8'd1, 8'd1, 1'b1);
    @(posedge clk);
    #1;
    chk("arst_valid_before", int'(out_valid), 1);
    @(negedge clk);
    #2;
    nreset = 1'b0;
    #1;
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_sum", int'(out_sum), 0);
    chk("arst_count", int'(out_count), 0);
    @(negedge clk);
    nreset = 1'b1;
    beat(8'd4, 8'd4, 8'd4, 1'b1);
    get_result("arst_fresh", 12, 1);

    // Wrap-around on the 10-bit accumulator: 1530 mod 1024 = 506.
    @(negedge clk);
    in_valid10 = 1'b1;
    in_data = {8'd255, 8'd255, 8'd255};
    in_last = 1'b0;
    chk("w10_in_ready", int'(in_ready10), 1);
    @(posedge clk);
    #1;
    in_last = 1'b1;
    @(posedge clk);
    #1;
    in_valid10 = 1'b0;
    in_last = 1'b0;
    @(posedge clk);
    #1;
    chk("w10_valid", int'(out_valid10), 1);
    chk("w10_sum", int'(out_sum10), 506);
    chk("w10_count", int'(out_count10), 2);
    out_ready10 = 1'b1;
    @(posedge clk);
    #1;
    out_ready10 = 1'b0;
    chk("w10_valid_after", int'(out_valid10), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
